// File: rtl/csa_operand_loader.sv
// Collects up to NUM_OPS operand bytes, drives them in parallel to the csa, then captures its sum.
// Latency: the sum is offered SETTLE_CYC edges after the final operand beat is accepted.
// Backpressure: in_ready drops from end of frame until the out_valid/out_ready handshake.
module csa_operand_loader #(
    parameter int DATA_W     = 8,
    parameter int NUM_OPS    = 10,
    parameter int SUM_W      = 18,
    parameter int SETTLE_CYC = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_W-1:0]           in_data,
    input  logic                        in_last,
    output logic [NUM_OPS*DATA_W-1:0]   op_bus,
    input  logic [SUM_W-1:0]            csa_sum,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [SUM_W-1:0]            out_sum,
    output logic                        sum_err
);

    localparam int IDX_W = $clog2(NUM_OPS + 1);
    localparam int CNT_W = $clog2(SETTLE_CYC + 1);

    typedef enum logic [1:0] {
        LOAD,
        SETTLE,
        DONE
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [CNT_W-1:0]   cnt;
    logic               accept;
    logic               last_beat;

    assign accept    = in_valid & in_ready;
    assign last_beat = in_last | (idx == IDX_W'(NUM_OPS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LOAD;
            idx       <= '0;
            cnt       <= '0;
            op_bus    <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            sum_err   <= 1'b0;
        end else begin
            unique case (state)
                LOAD: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        idx <= idx + IDX_W'(1);
                        // Short frames leave no stale operands in the unused upper slots.
                        for (int i = 0; i < NUM_OPS; i++) begin
                            if (IDX_W'(i) == idx)
                                op_bus[i*DATA_W +: DATA_W] <= in_data;
                            else if (last_beat && (IDX_W'(i) > idx))
                                op_bus[i*DATA_W +: DATA_W] <= '0;
                        end
                        if (last_beat) begin
                            in_ready <= 1'b0;
                            cnt      <= CNT_W'(SETTLE_CYC);
                            state    <= SETTLE;
                        end
                    end
                end
                SETTLE: begin
                    if (cnt == CNT_W'(1)) begin
                        out_sum   <= csa_sum;
                        sum_err   <= |csa_sum[SUM_W-1:DATA_W+4];
                        out_valid <= 1'b1;
                        cnt       <= '0;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        op_bus    <= '0;
                        idx       <= '0;
                        in_ready  <= 1'b1;
                        state     <= LOAD;
                    end
                end
                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csa_operand_loader.sv
// Directed bench for csa_operand_loader with a behavioural csa model closing the loop.
module tb_csa_operand_loader;

    logic        clk;
    logic        rst_n;
    logic        in_valid, in_ready, in_last, out_valid, out_ready, sum_err;
    logic [7:0]  in_data;
    logic [79:0] op_bus;
    logic [17:0] csa_sum, out_sum, err_inject;

    logic        in_valid3, in_ready3, in_last3, out_valid3, out_ready3, sum_err3;
    logic [7:0]  in_data3;
    logic [79:0] op_bus3;
    logic [17:0] csa_sum3, out_sum3;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int          nbeats;
        logic [79:0] data;
        logic        use_last;
        logic        gaps;
        logic [17:0] inject;
        logic [17:0] exp_sum;
        logic        exp_err;
        logic [79:0] exp_bus;
    } vec_t;

    vec_t vecs[6];

    function automatic logic [17:0] csa_model(input logic [79:0] b);
        logic [17:0] s;
        s = '0;
        for (int i = 0; i < 10; i++) s = s + 18'(b[i*8 +: 8]);
        return s;
    endfunction

    assign csa_sum  = csa_model(op_bus) ^ err_inject;
    assign csa_sum3 = csa_model(op_bus3);

    csa_operand_loader u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .op_bus(op_bus), .csa_sum(csa_sum),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .sum_err(sum_err)
    );

    csa_operand_loader #(.SETTLE_CYC(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3), .in_last(in_last3),
        .op_bus(op_bus3), .csa_sum(csa_sum3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_sum(out_sum3), .sum_err(sum_err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int  b;
        int  cyc;
        int  lat;
        logic will_accept;
        b = 0;
        cyc = 0;
        err_inject = v.inject;
        while (b < v.nbeats && cyc < 200) begin
            if (v.gaps && (cyc % 2 == 1)) begin
                in_valid = 1'b0;
                in_last  = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = v.data[b*8 +: 8];
                in_last  = v.use_last && (b == v.nbeats - 1);
            end
            will_accept = in_valid & in_ready;
            step();
            if (will_accept) b++;
            cyc++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check($sformatf("v%0d beats_accepted", id), 80'(b), 80'(v.nbeats));
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        check($sformatf("v%0d latency", id), 80'(lat), 80'd1);
        check($sformatf("v%0d out_sum", id), 80'(out_sum), 80'(v.exp_sum));
        check($sformatf("v%0d sum_err", id), 80'(sum_err), 80'(v.exp_err));
        check($sformatf("v%0d op_bus", id), op_bus, v.exp_bus);
        check($sformatf("v%0d in_ready_done", id), 80'(in_ready), 80'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        err_inject = '0;
        check($sformatf("v%0d out_valid_after_hs", id), 80'(out_valid), 80'd0);
        check($sformatf("v%0d in_ready_after_hs", id), 80'(in_ready), 80'd1);
        check($sformatf("v%0d op_bus_cleared", id), op_bus, 80'd0);
    endtask

    initial begin
        int lat;
        int seen;
        vec_t v;

        vecs[0] = '{10, 80'hFFFFFFFFFFFFFFFFFFFF, 1'b1, 1'b0, 18'h0, 18'd2550, 1'b0, 80'hFFFFFFFFFFFFFFFFFFFF};
        vecs[1] = '{3,  80'h030201,               1'b1, 1'b0, 18'h0, 18'd6,    1'b0, 80'h030201};
        vecs[2] = '{10, 80'h09080706050403020100, 1'b0, 1'b1, 18'h0, 18'd45,   1'b0, 80'h09080706050403020100};
        vecs[3] = '{10, 80'h01010101010101010101, 1'b0, 1'b0, 18'h0, 18'd10,   1'b0, 80'h01010101010101010101};
        vecs[4] = '{2,  80'h2010,                 1'b1, 1'b0, 18'h1000, 18'h1030, 1'b1, 80'h2010};
        vecs[5] = '{1,  80'h05,                   1'b1, 1'b0, 18'h0, 18'd5,    1'b0, 80'h05};

        rst_n = 1'b0;
        in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0; err_inject = '0;
        in_valid3 = 1'b0; in_last3 = 1'b0; in_data3 = '0; out_ready3 = 1'b0;

        step();
        step();
        check("rst in_ready", 80'(in_ready), 80'd0);
        check("rst out_valid", 80'(out_valid), 80'd0);
        check("rst op_bus", op_bus, 80'd0);
        check("rst out_sum", 80'(out_sum), 80'd0);
        check("rst sum_err", 80'(sum_err), 80'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("in_ready before first edge", 80'(in_ready), 80'd0);
        step();
        check("in_ready after first edge", 80'(in_ready), 80'd1);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Hold off the consumer in DONE while the producer keeps offering a beat.
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'(7 + i);
            in_last = (i == 2);
            step();
        end
        in_data = 8'h55;
        in_last = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        check("bp latency", 80'(lat), 80'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("bp out_sum c%0d", i), 80'(out_sum), 80'd24);
            check($sformatf("bp op_bus c%0d", i), op_bus, 80'h090807);
            check($sformatf("bp in_ready c%0d", i), 80'(in_ready), 80'd0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        in_valid = 1'b0;
        check("bp in_ready after hs", 80'(in_ready), 80'd1);
        check("bp op_bus after hs", op_bus, 80'd0);
        check("bp out_valid after hs", 80'(out_valid), 80'd0);

        // Reset in the middle of a partial frame.
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'(8'h11 * (i + 1));
            step();
        end
        in_valid = 1'b0;
        check("partial op_bus", op_bus, 80'h44332211);
        rst_n = 1'b0;
        #3;
        check("midrst op_bus", op_bus, 80'd0);
        check("midrst in_ready", 80'(in_ready), 80'd0);
        step();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (out_valid) seen++;
        end
        check("midrst no out_valid", 80'(seen), 80'd0);
        v = vecs[3];
        run_vec(v, 10);

        // Longer settle time on the second instance.
        in_valid3 = 1'b1;
        in_data3  = 8'h80;
        in_last3  = 1'b1;
        check("s3 in_ready", 80'(in_ready3), 80'd1);
        step();
        in_valid3 = 1'b0;
        in_last3  = 1'b0;
        lat = 0;
        while (!out_valid3 && lat < 20) begin
            step();
            lat++;
        end
        check("s3 latency", 80'(lat), 80'd3);
        check("s3 out_sum", 80'(out_sum3), 80'd128);
        check("s3 sum_err", 80'(sum_err3), 80'd0);
        check("s3 op_bus", op_bus3, 80'h80);
        out_ready3 = 1'b1;
        step();
        out_ready3 = 1'b0;
        check("s3 out_valid after hs", 80'(out_valid3), 80'd0);
        check("s3 in_ready after hs", 80'(in_ready3), 80'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
